// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: drives the instruction ROM address and
// provides the run/done handshake with a saturating cycle counter.
module pc_fetch_unit #(
  parameter int unsigned W  = 8,
  parameter int unsigned PW = 10,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          Jump,
  input  logic [W-1:0]  JumpReg,
  input  logic          Branch,
  input  logic          BranchTaken,
  input  logic [W-1:0]  Offset,
  output logic [PW-1:0] PC,
  output logic          InstrValid,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [PW-1:0] pcNext;
  logic [CW-1:0] countNext;
  logic [PW-1:0] jumpTarget;
  logic [PW-1:0] offsetExt;
  logic [PW-1:0] branchTarget;

  // JumpReg is zero-extended (or truncated) to PC width; Offset is sign-extended.
  assign jumpTarget   = PW'(JumpReg);
  assign offsetExt    = PW'($signed(Offset));
  assign branchTarget = PC + offsetExt;

  // Next-state, next-PC and next-count selection.
  always_comb begin
    stateNext = state;
    pcNext    = PC;
    countNext = CycleCount;
    case (state)
      StIdle, StDone: begin
        if (Start) begin
          stateNext = StRun;
          pcNext    = '0;
          countNext = '0;
        end
      end
      StRun: begin
        if (CycleCount != {CW{1'b1}}) countNext = CycleCount + CW'(1);
        // A stall freezes the PC and defers Halt, Jump and Branch.
        if (!Stall) begin
          if (Halt)                       stateNext = StDone;
          else if (Jump)                  pcNext    = jumpTarget;
          else if (Branch && BranchTaken) pcNext    = branchTarget;
          else                            pcNext    = PC + PW'(1);
        end
      end
      default: stateNext = StIdle;
    endcase
  end

  // State, PC, counter and status flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= StIdle;
      PC         <= '0;
      CycleCount <= '0;
      Running    <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= stateNext;
      PC         <= pcNext;
      CycleCount <= countNext;
      Running    <= (stateNext == StRun);
      Done       <= (stateNext == StDone);
    end
  end

  // Valid fetch only in a running, non-stalled cycle.
  assign InstrValid = (state == StRun) && !Stall;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit, with a narrow-counter second instance
// to exercise CycleCount saturation.
module tb_pc_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, Stall, Jump, Branch, BranchTaken;
  logic [7:0] JumpReg, Offset;
  logic [9:0] PC, PCs;
  logic       InstrValid, Running, Done;
  logic       InstrValidS, RunningS, DoneS;
  logic [15:0] CycleCount;
  logic [2:0]  CycleCountS;

  int nChecks = 0;
  int nPass   = 0;

  always #5 Clk = ~Clk;

  pc_fetch_unit #(.W(8), .PW(10), .CW(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch), .BranchTaken(BranchTaken),
    .Offset(Offset), .PC(PC), .InstrValid(InstrValid), .Running(Running),
    .Done(Done), .CycleCount(CycleCount)
  );

  pc_fetch_unit #(.W(8), .PW(10), .CW(3)) dutSat (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch), .BranchTaken(BranchTaken),
    .Offset(Offset), .PC(PCs), .InstrValid(InstrValidS), .Running(RunningS),
    .Done(DoneS), .CycleCount(CycleCountS)
  );

  typedef struct {
    logic       st, ha, sl, ju;
    logic [7:0] jr;
    logic       br, bt;
    logic [7:0] of;
    logic       eVal;
    logic [9:0] ePC;
    logic       eRun, eDone;
    logic [15:0] eCnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, ha, sl, ju, input logic [7:0] jr,
                              input logic br, bt, input logic [7:0] of,
                              input logic eVal, input logic [9:0] ePC,
                              input logic eRun, eDone, input logic [15:0] eCnt);
    vec_t v;
    v.st = st; v.ha = ha; v.sl = sl; v.ju = ju; v.jr = jr;
    v.br = br; v.bt = bt; v.of = of; v.eVal = eVal; v.ePC = ePC;
    v.eRun = eRun; v.eDone = eDone; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else nPass++;
  endtask

  task automatic drive(input logic st, ha, sl, ju, input logic [7:0] jr,
                       input logic br, bt, input logic [7:0] of);
    Start = st; Halt = ha; Stall = sl; Jump = ju; JumpReg = jr;
    Branch = br; BranchTaken = bt; Offset = of;
  endtask

  // Drive one vector, check the pre-edge valid, then the post-edge state.
  task automatic step(input int idx, input vec_t v);
    logic [15:0] satExp;
    @(negedge Clk);
    drive(v.st, v.ha, v.sl, v.ju, v.jr, v.br, v.bt, v.of);
    #1;
    chk($sformatf("v%0d InstrValid", idx), 32'(InstrValid), 32'(v.eVal));
    @(posedge Clk);
    #1;
    satExp = (v.eCnt > 16'd7) ? 16'd7 : v.eCnt;
    chk($sformatf("v%0d PC", idx), 32'(PC), 32'(v.ePC));
    chk($sformatf("v%0d Running", idx), 32'(Running), 32'(v.eRun));
    chk($sformatf("v%0d Done", idx), 32'(Done), 32'(v.eDone));
    chk($sformatf("v%0d CycleCount", idx), 32'(CycleCount), 32'(v.eCnt));
    chk($sformatf("v%0d SatCount", idx), 32'(CycleCountS), 32'(satExp));
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 0, 0, 8'h00);

    vecs.push_back(mk(1,0,0,0,8'h00,0,0,8'h00, 0,10'h000,1,0,16'd0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00, 1,10'(i),1,0,16'(i)));
    vecs.push_back(mk(0,0,0,1,8'h40,1,1,8'h05, 1,10'h040,1,0,16'd6));
    vecs.push_back(mk(0,0,0,1,8'h10,0,0,8'h00, 1,10'h010,1,0,16'd7));
    vecs.push_back(mk(0,0,0,0,8'h00,1,1,8'hFC, 1,10'h00C,1,0,16'd8));
    vecs.push_back(mk(0,0,0,1,8'h10,0,0,8'h00, 1,10'h010,1,0,16'd9));
    vecs.push_back(mk(0,0,0,0,8'h00,1,0,8'hFC, 1,10'h011,1,0,16'd10));
    vecs.push_back(mk(1,0,0,0,8'h00,0,0,8'h00, 1,10'h012,1,0,16'd11));
    vecs.push_back(mk(0,0,0,1,8'h07,0,0,8'h00, 1,10'h007,1,0,16'd12));
    vecs.push_back(mk(0,0,1,1,8'h55,1,1,8'h20, 0,10'h007,1,0,16'd13));
    vecs.push_back(mk(0,0,1,1,8'h55,1,1,8'h20, 0,10'h007,1,0,16'd14));
    vecs.push_back(mk(0,1,1,1,8'h55,1,1,8'h20, 0,10'h007,1,0,16'd15));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00, 1,10'h008,1,0,16'd16));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00, 1,10'h009,1,0,16'd17));
    vecs.push_back(mk(0,1,0,1,8'h22,0,0,8'h00, 1,10'h009,0,1,16'd18));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,1,i[0],1,8'h33,1,1,8'h01, 0,10'h009,0,1,16'd18));
    vecs.push_back(mk(1,0,0,0,8'h00,0,0,8'h00, 0,10'h000,1,0,16'd0));
    vecs.push_back(mk(0,0,0,0,8'h00,1,1,8'hFF, 1,10'h3FF,1,0,16'd1));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00, 1,10'h000,1,0,16'd2));
    vecs.push_back(mk(0,0,0,0,8'h00,1,1,8'h7F, 1,10'h07F,1,0,16'd3));
    vecs.push_back(mk(0,0,0,0,8'h00,1,1,8'h80, 1,10'h3FF,1,0,16'd4));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00, 1,10'h000,1,0,16'd5));

    // Reset state.
    repeat (2) @(posedge Clk);
    #1;
    chk("reset PC", 32'(PC), 32'h0);
    chk("reset Running", 32'(Running), 32'h0);
    chk("reset Done", 32'(Done), 32'h0);
    chk("reset InstrValid", 32'(InstrValid), 32'h0);
    chk("reset CycleCount", 32'(CycleCount), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (vecs[i]) step(i, vecs[i]);

    // Reset mid-RUN returns everything to zero in one edge.
    @(negedge Clk);
    Reset = 1'b1;
    drive(0, 0, 0, 1, 8'h44, 1, 1, 8'h02);
    @(posedge Clk);
    #1;
    chk("midreset PC", 32'(PC), 32'h0);
    chk("midreset Running", 32'(Running), 32'h0);
    chk("midreset Done", 32'(Done), 32'h0);
    chk("midreset InstrValid", 32'(InstrValid), 32'h0);
    chk("midreset CycleCount", 32'(CycleCount), 32'h0);

    // Control inputs in IDLE must not move the PC.
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("idle%0d PC", i), 32'(PC), 32'h0);
      chk($sformatf("idle%0d Running", i), 32'(Running), 32'h0);
      chk($sformatf("idle%0d InstrValid", i), 32'(InstrValid), 32'h0);
      chk($sformatf("idle%0d CycleCount", i), 32'(CycleCount), 32'h0);
    end

    // Reset dominates a simultaneous Start.
    @(negedge Clk);
    Reset = 1'b1;
    drive(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    @(posedge Clk);
    #1;
    chk("reset+start Running", 32'(Running), 32'h0);
    chk("reset+start PC", 32'(PC), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    Start = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
